npu_fifo: RTL and testbench
===========================

NPU_FIFO -- requirements
Module: npu_fifo

Interface
REQ-001 SHALL have parameter SIZE, default 2, number of storage entries; legal range 1..64.
REQ-002 SHALL have parameter DWIDTH, default 32, data width in bits.
REQ-003 SHALL have parameter FRCVAL, default 1'b0; 1 removes the write-to-read bypass, so valid_read depends only on stored state.
REQ-004 SHALL have parameter FRCACC, default 1'b0; 1 removes the read-to-write pass-through, so accept_write depends only on stored state.
REQ-005 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_a, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port valid_write, input, 1, producer offers data_write.
REQ-008 SHALL have port accept_write, output, 1, FIFO takes data_write this cycle.
REQ-009 SHALL have port data_write, input, DWIDTH, write data.
REQ-010 SHALL have port valid_read, output, 1, data_read is valid.
REQ-011 SHALL have port accept_read, input, 1, consumer takes data_read this cycle.
REQ-012 SHALL have port data_read, output, DWIDTH, head data.

Function
REQ-013 SHALL define push = valid_write & accept_write and pop = valid_read & accept_read; a transfer occurs only on the clock edge where both signals of a pair are high.
REQ-014 SHALL keep an occupancy count 0..SIZE with full = (count==SIZE) and empty = (count==0).
REQ-015 SHALL drive accept_write = !full when FRCACC=1, and accept_write = !full | accept_read when FRCACC=0.
REQ-016 SHALL drive valid_read = !empty when FRCVAL=1, and valid_read = !empty | valid_write when FRCVAL=0.
REQ-017 SHALL drive data_read from the head entry when not empty; when empty with FRCVAL=0, SHALL drive data_read = data_write (bypass).
REQ-018 SHALL, when empty with FRCVAL=0 and push & pop both occur, pass data straight through and leave count and storage unchanged.
REQ-019 SHALL update count as count+1 on push only, count-1 on pop only, and leave it unchanged on push & pop; storage SHALL write at the tail and read from the head.
REQ-020 SHALL, when full with FRCACC=0 and push & pop both occur, pop the head and write the new entry in the same cycle with count staying at SIZE.
REQ-021 SHALL wrap the read and write pointers from SIZE-1 to 0, including for SIZE values that are not powers of 2.
REQ-022 SHALL preserve data order and never drop or duplicate an entry.
REQ-023 SHALL show the entry written in cycle N on data_read at cycle N+1 or later (one-cycle latency), except through the bypass path.
REQ-024 SHALL ignore data_write when valid_write is 0, and SHALL leave data_read unspecified but stable when valid_read is 0.

Reset
REQ-025 SHALL on rst_a=1 immediately clear count, both pointers and all storage to 0.
REQ-026 SHALL during reset drive valid_read = 0 when FRCVAL=1 (otherwise = valid_write), accept_write = 1, and data_read = 0 when FRCVAL=1 (otherwise data_write).
REQ-027 SHALL discard any stored entries when reset is asserted in the middle of operation.

Structure
REQ-028 SHALL need no shared package; pointer and count widths SHALL be local constants derived from SIZE with $clog2.
REQ-029 SHALL be a single flat module with no sub-modules; storage is a register array of SIZE x DWIDTH.

Verification
REQ-030 Bench SHALL cover: SIZE=1, FRCVAL=0; write 0xA5A5A5A5 with accept_read=0 -> next cycle valid_read=1, data_read=0xA5A5A5A5, accept_write=0; then accept_read=1 -> the same cycle accept_write=1.
REQ-031 Bench SHALL cover: SIZE=4; write 1,2,3,4 back-to-back with no reads -> count reaches 4 and accept_write=0; then read 4 -> data 1,2,3,4 in order, then valid_read=0.
REQ-032 Bench SHALL cover: SIZE=2, FRCVAL=0, empty; valid_write=1 with data 0x55, accept_read=1 -> valid_read=1, data_read=0x55 in the same cycle, and count stays 0.
REQ-033 Bench SHALL cover: SIZE=2, FRCVAL=1, empty; write 0x55 -> valid_read=0 in that cycle and valid_read=1 with 0x55 in the next cycle.
REQ-034 Bench SHALL cover: SIZE=3, random valid and accept over 10000 cycles -> scoreboard matches in order, pointers wrap correctly, and there is no overflow or underflow.
REQ-035 Bench SHALL cover: assert rst_a while holding 2 entries -> valid_read drops immediately when FRCVAL=1, and the first write after reset is read first.

Source files
------------

// File: rtl/npu_fifo.sv
// rtl/npu_fifo.sv - parameterised valid/accept FIFO with optional bypass and pass-through
//
// Ports:
//   clk          rising-edge clock
//   rst_a        asynchronous active-high reset; clears count, pointers and storage
//   valid_write  producer offers data_write
//   accept_write FIFO takes data_write this cycle
//   data_write   write data (DWIDTH bits)
//   valid_read   data_read holds a valid entry
//   accept_read  consumer takes data_read this cycle
//   data_read    head entry, or data_write while empty when FRCVAL=0
//
// Parameters:
//   SIZE   number of entries (1..64, any value, not only powers of 2)
//   DWIDTH data width
//   FRCVAL 1 = valid_read depends only on stored state (no write-to-read bypass)
//   FRCACC 1 = accept_write depends only on stored state (no read-to-write pass-through)
module npu_fifo #(
  parameter int SIZE   = 2,
  parameter int DWIDTH = 32,
  parameter bit FRCVAL = 1'b0,
  parameter bit FRCACC = 1'b0
) (
  input  logic              clk,
  input  logic              rst_a,
  input  logic              valid_write,
  output logic              accept_write,
  input  logic [DWIDTH-1:0] data_write,
  output logic              valid_read,
  input  logic              accept_read,
  output logic [DWIDTH-1:0] data_read
);

  localparam int PW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CW = $clog2(SIZE + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(SIZE - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(SIZE);

  logic [DWIDTH-1:0] mem [SIZE];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic bypass;

  // Pointers wrap explicitly at SIZE-1 so non-power-of-2 depths work.
  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full  = (count == FULL_CNT);
    empty = (count == '0);

    accept_write = FRCACC ? !full : (!full || accept_read);
    valid_read   = FRCVAL ? !empty : (!empty || valid_write);

    // While empty with bypass enabled the head is the incoming word.
    if (empty && !FRCVAL) begin
      data_read = data_write;
    end else begin
      data_read = mem[rd_ptr];
    end

    push = valid_write && accept_write;
    pop  = valid_read && accept_read;

    // Word flows straight through an empty FIFO; storage is never touched.
    bypass = !FRCVAL && empty && push && pop;
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < SIZE; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push && !bypass) begin
        mem[wr_ptr] <= data_write;
        wr_ptr      <= inc_ptr(wr_ptr);
      end
      if (pop && !bypass) begin
        rd_ptr <= inc_ptr(rd_ptr);
      end
      // Simultaneous push and pop (including full pass-through) keeps count.
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_npu_fifo.sv
// tb/tb_npu_fifo.sv - self-checking bench for npu_fifo across several parameter sets
module tb_npu_fifo;

  typedef logic [31:0] wq_t[$];

  logic clk = 1'b0;
  logic rst_a;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // SIZE=1, FRCVAL=0
  logic s1_vw, s1_aw, s1_vr, s1_ar;
  logic [31:0] s1_dw, s1_dr;
  // SIZE=4, defaults
  logic s4_vw, s4_aw, s4_vr, s4_ar;
  logic [31:0] s4_dw, s4_dr;
  // SIZE=2, FRCVAL=0
  logic sb_vw, sb_aw, sb_vr, sb_ar;
  logic [31:0] sb_dw, sb_dr;
  // SIZE=2, FRCVAL=1
  logic sv_vw, sv_aw, sv_vr, sv_ar;
  logic [31:0] sv_dw, sv_dr;
  // SIZE=3 random: index 0 FRCVAL=0/FRCACC=0, index 1 FRCVAL=1/FRCACC=1
  logic r_vw [2];
  logic r_aw [2];
  logic r_vr [2];
  logic r_ar [2];
  logic [31:0] r_dw [2];
  logic [31:0] r_dr [2];

  npu_fifo #(.SIZE(1), .DWIDTH(32), .FRCVAL(1'b0), .FRCACC(1'b0)) u_s1 (
    .clk(clk), .rst_a(rst_a), .valid_write(s1_vw), .accept_write(s1_aw), .data_write(s1_dw),
    .valid_read(s1_vr), .accept_read(s1_ar), .data_read(s1_dr));

  npu_fifo #(.SIZE(4), .DWIDTH(32), .FRCVAL(1'b0), .FRCACC(1'b0)) u_s4 (
    .clk(clk), .rst_a(rst_a), .valid_write(s4_vw), .accept_write(s4_aw), .data_write(s4_dw),
    .valid_read(s4_vr), .accept_read(s4_ar), .data_read(s4_dr));

  npu_fifo #(.SIZE(2), .DWIDTH(32), .FRCVAL(1'b0), .FRCACC(1'b0)) u_sb (
    .clk(clk), .rst_a(rst_a), .valid_write(sb_vw), .accept_write(sb_aw), .data_write(sb_dw),
    .valid_read(sb_vr), .accept_read(sb_ar), .data_read(sb_dr));

  npu_fifo #(.SIZE(2), .DWIDTH(32), .FRCVAL(1'b1), .FRCACC(1'b0)) u_sv (
    .clk(clk), .rst_a(rst_a), .valid_write(sv_vw), .accept_write(sv_aw), .data_write(sv_dw),
    .valid_read(sv_vr), .accept_read(sv_ar), .data_read(sv_dr));

  npu_fifo #(.SIZE(3), .DWIDTH(32), .FRCVAL(1'b0), .FRCACC(1'b0)) u_r0 (
    .clk(clk), .rst_a(rst_a), .valid_write(r_vw[0]), .accept_write(r_aw[0]), .data_write(r_dw[0]),
    .valid_read(r_vr[0]), .accept_read(r_ar[0]), .data_read(r_dr[0]));

  npu_fifo #(.SIZE(3), .DWIDTH(32), .FRCVAL(1'b1), .FRCACC(1'b1)) u_r1 (
    .clk(clk), .rst_a(rst_a), .valid_write(r_vw[1]), .accept_write(r_aw[1]), .data_write(r_dw[1]),
    .valid_read(r_vr[1]), .accept_read(r_ar[1]), .data_read(r_dr[1]));

  task automatic idle_inputs();
    s1_vw = 0; s1_ar = 0; s1_dw = '0;
    s4_vw = 0; s4_ar = 0; s4_dw = '0;
    sb_vw = 0; sb_ar = 0; sb_dw = '0;
    sv_vw = 0; sv_ar = 0; sv_dw = '0;
    for (int k = 0; k < 2; k++) begin
      r_vw[k] = 0; r_ar[k] = 0; r_dw[k] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_a = 1'b1;
    #1;
    s1_vw = 1; s1_dw = 32'h0000_1234;
    #1;
    n_checks++; if (s1_aw !== 1'b1) begin n_errs++; $display("FAIL rst_s1_accept: got %0b want 1", s1_aw); end
    n_checks++; if (s1_vr !== 1'b1) begin n_errs++; $display("FAIL rst_s1_valid_follows_write: got %0b want 1", s1_vr); end
    n_checks++; if (s1_dr !== 32'h0000_1234) begin n_errs++; $display("FAIL rst_s1_data_follows_write: got %h want 00001234", s1_dr); end
    n_checks++; if (s4_vr !== 1'b0) begin n_errs++; $display("FAIL rst_s4_valid: got %0b want 0", s4_vr); end
    n_checks++; if (s4_aw !== 1'b1) begin n_errs++; $display("FAIL rst_s4_accept: got %0b want 1", s4_aw); end
    n_checks++; if (sv_vr !== 1'b0) begin n_errs++; $display("FAIL rst_sv_valid: got %0b want 0", sv_vr); end
    n_checks++; if (sv_dr !== 32'h0) begin n_errs++; $display("FAIL rst_sv_data: got %h want 0", sv_dr); end
    n_checks++; if (sv_aw !== 1'b1) begin n_errs++; $display("FAIL rst_sv_accept: got %0b want 1", sv_aw); end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic test_size1();
    do_reset();
    s1_vw = 1; s1_dw = 32'hA5A5_A5A5; s1_ar = 0;
    #1;
    n_checks++; if (s1_aw !== 1'b1) begin n_errs++; $display("FAIL s1_accept_empty: got %0b want 1", s1_aw); end
    @(negedge clk);
    s1_vw = 0; s1_dw = 32'h0;
    #1;
    n_checks++; if (s1_vr !== 1'b1) begin n_errs++; $display("FAIL s1_valid_after_write: got %0b want 1", s1_vr); end
    n_checks++; if (s1_dr !== 32'hA5A5_A5A5) begin n_errs++; $display("FAIL s1_data: got %h want a5a5a5a5", s1_dr); end
    n_checks++; if (s1_aw !== 1'b0) begin n_errs++; $display("FAIL s1_accept_full: got %0b want 0", s1_aw); end
    s1_ar = 1;
    #1;
    n_checks++; if (s1_aw !== 1'b1) begin n_errs++; $display("FAIL s1_accept_passthrough: got %0b want 1", s1_aw); end
    @(negedge clk);
    s1_ar = 0;
    #1;
    n_checks++; if (s1_vr !== 1'b0) begin n_errs++; $display("FAIL s1_valid_drained: got %0b want 0", s1_vr); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      s4_vw = 1; s4_dw = 32'(i);
      #1;
      n_checks++; if (s4_aw !== 1'b1) begin n_errs++; $display("FAIL s4_accept_fill%0d: got %0b want 1", i, s4_aw); end
      @(negedge clk);
    end
    s4_vw = 0;
    #1;
    n_checks++; if (s4_aw !== 1'b0) begin n_errs++; $display("FAIL s4_accept_full: got %0b want 0", s4_aw); end
    n_checks++; if (s4_dr !== 32'd1) begin n_errs++; $display("FAIL s4_head_full: got %h want 1", s4_dr); end
    // Full with simultaneous push and pop: head leaves, 5 enters.
    s4_vw = 1; s4_dw = 32'd5; s4_ar = 1;
    #1;
    n_checks++; if (s4_aw !== 1'b1) begin n_errs++; $display("FAIL s4_accept_full_pop: got %0b want 1", s4_aw); end
    n_checks++; if (s4_dr !== 32'd1) begin n_errs++; $display("FAIL s4_read1: got %h want 1", s4_dr); end
    @(negedge clk);
    s4_vw = 0;
    #1;
    n_checks++; if (s4_aw !== 1'b1) begin n_errs++; $display("FAIL s4_still_full_passthru: got %0b want 1", s4_aw); end
    for (int i = 2; i <= 5; i++) begin
      n_checks++; if (s4_vr !== 1'b1) begin n_errs++; $display("FAIL s4_valid_read%0d: got %0b want 1", i, s4_vr); end
      n_checks++; if (s4_dr !== 32'(i)) begin n_errs++; $display("FAIL s4_read%0d: got %h want %h", i, s4_dr, 32'(i)); end
      @(negedge clk);
      #1;
    end
    s4_ar = 0;
    #1;
    n_checks++; if (s4_vr !== 1'b0) begin n_errs++; $display("FAIL s4_valid_empty: got %0b want 0", s4_vr); end
  endtask

  task automatic test_bypass();
    do_reset();
    sb_vw = 1; sb_dw = 32'h55; sb_ar = 1;
    #1;
    n_checks++; if (sb_vr !== 1'b1) begin n_errs++; $display("FAIL bypass_valid: got %0b want 1", sb_vr); end
    n_checks++; if (sb_dr !== 32'h55) begin n_errs++; $display("FAIL bypass_data: got %h want 55", sb_dr); end
    n_checks++; if (sb_aw !== 1'b1) begin n_errs++; $display("FAIL bypass_accept: got %0b want 1", sb_aw); end
    @(negedge clk);
    sb_vw = 0; sb_ar = 0;
    #1;
    n_checks++; if (sb_vr !== 1'b0) begin n_errs++; $display("FAIL bypass_count_zero: got %0b want 0", sb_vr); end
    // Two writes must then be accepted, confirming nothing was stored by the bypass.
    sb_vw = 1; sb_dw = 32'h66;
    @(negedge clk);
    sb_dw = 32'h77;
    #1;
    n_checks++; if (sb_aw !== 1'b1) begin n_errs++; $display("FAIL bypass_room: got %0b want 1", sb_aw); end
    @(negedge clk);
    sb_vw = 0;
    #1;
    n_checks++; if (sb_dr !== 32'h66) begin n_errs++; $display("FAIL bypass_after_head: got %h want 66", sb_dr); end
  endtask

  task automatic test_frcval();
    do_reset();
    sv_vw = 1; sv_dw = 32'h55; sv_ar = 0;
    #1;
    n_checks++; if (sv_vr !== 1'b0) begin n_errs++; $display("FAIL frcval_no_bypass: got %0b want 0", sv_vr); end
    @(negedge clk);
    sv_vw = 0;
    #1;
    n_checks++; if (sv_vr !== 1'b1) begin n_errs++; $display("FAIL frcval_valid_next: got %0b want 1", sv_vr); end
    n_checks++; if (sv_dr !== 32'h55) begin n_errs++; $display("FAIL frcval_data_next: got %h want 55", sv_dr); end
  endtask

  task automatic test_reset_mid();
    // Continues from test_frcval: one entry held, add a second.
    sv_vw = 1; sv_dw = 32'h66;
    @(negedge clk);
    sv_vw = 0;
    #1;
    n_checks++; if (sv_aw !== 1'b0) begin n_errs++; $display("FAIL mid_two_held: got %0b want 0", sv_aw); end
    #2;
    rst_a = 1'b1;
    #1;
    n_checks++; if (sv_vr !== 1'b0) begin n_errs++; $display("FAIL mid_valid_drop: got %0b want 0", sv_vr); end
    n_checks++; if (sv_dr !== 32'h0) begin n_errs++; $display("FAIL mid_data_zero: got %h want 0", sv_dr); end
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    n_checks++; if (sv_vr !== 1'b0) begin n_errs++; $display("FAIL mid_empty_after: got %0b want 0", sv_vr); end
    sv_vw = 1; sv_dw = 32'h77;
    @(negedge clk);
    sv_dw = 32'h88;
    @(negedge clk);
    sv_vw = 0; sv_ar = 1;
    #1;
    n_checks++; if (sv_dr !== 32'h77) begin n_errs++; $display("FAIL mid_first_after_reset: got %h want 77", sv_dr); end
    @(negedge clk);
    #1;
    n_checks++; if (sv_dr !== 32'h88) begin n_errs++; $display("FAIL mid_second_after_reset: got %h want 88", sv_dr); end
    sv_ar = 0;
  endtask

  // Reference: an ordered queue of up to SIZE words; handshake rules come
  // straight from occupancy and the two option bits.
  task automatic model_cycle(input int k, input int size, input bit fv, input bit fa,
                             input logic vw, input logic ar, input logic [31:0] dw,
                             input logic aw, input logic vr, input logic [31:0] dr,
                             inout wq_t q);
    int  n;
    bit  exp_aw, exp_vr, push, pop;
    n      = q.size();
    exp_aw = fa ? (n < size) : ((n < size) || ar);
    exp_vr = fv ? (n > 0) : ((n > 0) || vw);
    n_checks++; if (aw !== exp_aw) begin n_errs++; $display("FAIL rnd%0d_accept_write: got %0b want %0b occ=%0d", k, aw, exp_aw, n); end
    n_checks++; if (vr !== exp_vr) begin n_errs++; $display("FAIL rnd%0d_valid_read: got %0b want %0b occ=%0d", k, vr, exp_vr, n); end
    if (exp_vr) begin
      n_checks++;
      if (dr !== ((n > 0) ? q[0] : dw)) begin
        n_errs++;
        $display("FAIL rnd%0d_data_read: got %h want %h occ=%0d", k, dr, (n > 0) ? q[0] : dw, n);
      end
    end
    push = vw && exp_aw;
    pop  = exp_vr && ar;
    if (pop && n > 0) void'(q.pop_front());
    if (push && !(pop && n == 0)) q.push_back(dw);
  endtask

  task automatic test_random();
    wq_t q0, q1;
    int  wr_pct, rd_pct;
    do_reset();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      case ((cyc / 500) % 3)
        0:       begin wr_pct = 80; rd_pct = 30; end
        1:       begin wr_pct = 30; rd_pct = 80; end
        default: begin wr_pct = 55; rd_pct = 55; end
      endcase
      for (int k = 0; k < 2; k++) begin
        r_vw[k] = ($urandom_range(0, 99) < wr_pct);
        r_ar[k] = ($urandom_range(0, 99) < rd_pct);
        r_dw[k] = $urandom;
      end
      #1;
      model_cycle(0, 3, 1'b0, 1'b0, r_vw[0], r_ar[0], r_dw[0], r_aw[0], r_vr[0], r_dr[0], q0);
      model_cycle(1, 3, 1'b1, 1'b1, r_vw[1], r_ar[1], r_dw[1], r_aw[1], r_vr[1], r_dr[1], q1);
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    rst_a = 1'b1;
    idle_inputs();
    test_reset();
    test_size1();
    test_fill_drain();
    test_bypass();
    test_frcval();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
